// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, oversampling counters, checker enables and frame result pulses.
// Define UART_RX_CTRL_ERR_CNT_EN to add the saturating error counter output err_cnt_rxc.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk_rxc,
    input  logic                  rst_rxc,
    input  logic                  rx_in_rxc,
    input  logic [PRESCALE_W-1:0] prescale_rxc,
    input  logic                  par_en_rxc,
    input  logic                  strt_glitch_rxc,
    input  logic                  par_err_rxc,
    input  logic                  stop_error_rxc,
    output logic [PRESCALE_W-1:0] edge_cnt_rxc,
    output logic                  dat_samp_en_rxc,
    output logic                  strt_chk_en_rxc,
    output logic                  deser_en_rxc,
    output logic                  par_chk_en_rxc,
    output logic                  stop_check_en_rxc,
    output logic                  data_valid_rxc,
    output logic                  par_fail_rxc,
    output logic                  frame_err_rxc,
`ifdef UART_RX_CTRL_ERR_CNT_EN
    output logic [7:0]            err_cnt_rxc,
`endif
    output logic                  busy_rxc
);

    localparam int BW = 4;
    localparam logic [BW-1:0]         LAST_DATA = BW'(DATA_WIDTH);
    localparam logic [PRESCALE_W-1:0] P_RST     = PRESCALE_W'(8);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic                  e_q, e_d;
    logic                  strt_q, strt_d;
    logic                  deser_q, deser_d;
    logic                  par_q, par_d;
    logic                  stop_q, stop_d;
    logic                  valid_q, valid_d;
    logic                  pfail_q, pfail_d;
    logic                  ferr_q, ferr_d;
    logic                  busy_q, busy_d;

    logic                  last, launch;
    logic [PRESCALE_W-1:0] p_m1, pd_m2;

    assign p_m1 = p_q - PRESCALE_W'(1);
    assign last = (edge_q == p_m1);

    always_comb begin
        state_d = state_q;
        edge_d  = edge_q;
        bit_d   = bit_q;
        p_d     = p_q;
        e_d     = e_q;
        valid_d = 1'b0;
        pfail_d = 1'b0;
        ferr_d  = 1'b0;
        launch  = 1'b0;
        case (state_q)
            IDLE:   launch = ~rx_in_rxc;
            START:  if (last) state_d = strt_glitch_rxc ? IDLE : DATA;
            DATA:   if (last && bit_q == LAST_DATA) state_d = e_q ? PARITY : STOP;
            PARITY: if (last) begin
                        state_d = par_err_rxc ? IDLE : STOP;
                        pfail_d = par_err_rxc;
                    end
            // The stop decision doubles as IDLE's first sample, so a start bit right after stop loses no cycle.
            STOP:   if (last) begin
                        valid_d = ~stop_error_rxc;
                        ferr_d  = stop_error_rxc;
                        state_d = IDLE;
                        launch  = ~rx_in_rxc;
                    end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE) begin
            if (last) begin
                edge_d = '0;
                bit_d  = bit_q + BW'(1);
            end else begin
                edge_d = edge_q + PRESCALE_W'(1);
            end
        end
        if (launch) begin
            state_d = START;
            p_d     = prescale_rxc;
            e_d     = par_en_rxc;
            edge_d  = '0;
            bit_d   = '0;
        end
    end

    // Enables are registered from next-state values so they line up with edge_cnt == P-2.
    assign pd_m2 = p_d - PRESCALE_W'(2);

    always_comb begin
        strt_d  = (state_d == START)  && (edge_d == pd_m2);
        deser_d = (state_d == DATA)   && (edge_d == pd_m2);
        par_d   = (state_d == PARITY) && (edge_d == pd_m2);
        stop_d  = (state_d == STOP)   && (edge_d == pd_m2);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk_rxc) begin
        if (rst_rxc) begin
            state_q <= IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
            p_q     <= P_RST;
            e_q     <= 1'b0;
            strt_q  <= 1'b0;
            deser_q <= 1'b0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            valid_q <= 1'b0;
            pfail_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            p_q     <= p_d;
            e_q     <= e_d;
            strt_q  <= strt_d;
            deser_q <= deser_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            valid_q <= valid_d;
            pfail_q <= pfail_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

`ifdef UART_RX_CTRL_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic       err_inc;

    assign err_inc = ((state_q == START) && last && strt_glitch_rxc) | pfail_d | ferr_d;

    always_ff @(posedge clk_rxc) begin
        if (rst_rxc) begin
            err_cnt_q <= 8'd0;
        end else if (err_inc && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt_rxc = err_cnt_q;
`endif

    assign edge_cnt_rxc      = edge_q;
    assign dat_samp_en_rxc   = busy_q;
    assign busy_rxc          = busy_q;
    assign strt_chk_en_rxc   = strt_q;
    assign deser_en_rxc      = deser_q;
    assign par_chk_en_rxc    = par_q;
    assign stop_check_en_rxc = stop_q;
    assign data_valid_rxc    = valid_q;
    assign par_fail_rxc      = pfail_q;
    assign frame_err_rxc     = ferr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: table of single-frame cases plus reset, back-to-back and prescale-change sequences.
module tb_uart_rx_ctrl;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst, rx, par_en, strt_glitch, par_err, stop_err;
    logic [PW-1:0] prescale;
    logic [PW-1:0] edge_cnt;
    logic          samp_en, strt_en, deser_en, par_en_o, stop_en;
    logic          valid, pfail, ferr, busy;
`ifdef UART_RX_CTRL_ERR_CNT_EN
    logic [7:0]    err_cnt;
    int            exp_err = 0;
`endif

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .clk_rxc          (clk),
        .rst_rxc          (rst),
        .rx_in_rxc        (rx),
        .prescale_rxc     (prescale),
        .par_en_rxc       (par_en),
        .strt_glitch_rxc  (strt_glitch),
        .par_err_rxc      (par_err),
        .stop_error_rxc   (stop_err),
        .edge_cnt_rxc     (edge_cnt),
        .dat_samp_en_rxc  (samp_en),
        .strt_chk_en_rxc  (strt_en),
        .deser_en_rxc     (deser_en),
        .par_chk_en_rxc   (par_en_o),
        .stop_check_en_rxc(stop_en),
        .data_valid_rxc   (valid),
        .par_fail_rxc     (pfail),
        .frame_err_rxc    (ferr),
`ifdef UART_RX_CTRL_ERR_CNT_EN
        .err_cnt_rxc      (err_cnt),
`endif
        .busy_rxc         (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int r_deser, r_deser_bad, r_strt, r_par, r_stop, r_valid, r_valid_c0, r_valid_c1;
    int r_pfail, r_ferr, r_pulse_c, r_busy_bad, r_edge_bad, r_rst_bad;

    typedef struct {
        int         p;
        bit         e;
        logic [7:0] d;
        int         glen;
        bit         gl;
        bit         perr;
        bit         serr;
        int         exp_deser;
        int         exp_par;
        int         exp_stop;
        int         exp_valid;
        int         exp_pfail;
        int         exp_ferr;
        int         exp_end;
        int         exp_pulse_c;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Cycle c counts from the first DUT edge that sees rx low (c=0 is the first START cycle).
    task automatic run(input int p, input bit e, input int nfr, input logic [7:0] d0,
                       input logic [7:0] d1, input int glen, input bit gl, input bit perr,
                       input bit serr, input int rst_at, input int pchg_at, input int exp_end);
        int fl, ncyc, w, f, b, db;
        bit dec, exp_busy;
        int exp_edge;
        logic [7:0] d;
        fl   = (2 + DW + int'(e)) * p;
        ncyc = nfr * fl + p + 4;
        r_deser = 0; r_deser_bad = 0; r_strt = 0; r_par = 0; r_stop = 0;
        r_valid = 0; r_valid_c0 = -1; r_valid_c1 = -1; r_pfail = 0; r_ferr = 0;
        r_pulse_c = -1; r_busy_bad = 0; r_edge_bad = 0; r_rst_bad = 0;
        @(negedge clk);
        prescale = PW'(p);
        par_en   = e;
        rx       = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (rst_at >= 0 && c == rst_at + 1)
                r_rst_bad = int'(edge_cnt) + int'({samp_en, strt_en, deser_en, par_en_o,
                                                   stop_en, valid, pfail, ferr, busy});
            if (deser_en) begin
                r_deser++;
                if ((c % p) != p - 2 || ((c % fl) / p) < 1 || ((c % fl) / p) > DW) r_deser_bad++;
            end
            if (strt_en)  r_strt++;
            if (par_en_o) r_par++;
            if (stop_en)  r_stop++;
            if (pfail)    r_pfail++;
            if (ferr)     r_ferr++;
            if (valid) begin
                if (r_valid == 0) r_valid_c0 = c; else r_valid_c1 = c;
                r_valid++;
            end
            if ((valid || pfail || ferr) && r_pulse_c < 0) r_pulse_c = c;
            exp_busy = (c < exp_end);
            exp_edge = exp_busy ? (c % p) : 0;
            if (busy != exp_busy || samp_en != exp_busy) r_busy_bad++;
            if (int'(edge_cnt) != exp_edge) r_edge_bad++;
            w = c + 1;
            f = w / fl;
            b = (w % fl) / p;
            d = (f == 0) ? d0 : d1;
            if (f >= nfr || (rst_at >= 0 && c >= rst_at)) rx = 1'b1;
            else if (glen > 0) rx = (w < glen) ? 1'b0 : 1'b1;
            else if (b == 0)   rx = 1'b0;
            else if (b <= DW)  rx = d[b-1];
            else if (b == DW + 1 && e) rx = ^d;
            else rx = 1'b1;
            dec = ((c % p) == p - 1) && (c < fl);
            db  = c / p;
            strt_glitch = gl   && dec && db == 0;
            par_err     = perr && dec && db == DW + 1;
            stop_err    = serr && dec && db == DW + 1 + int'(e);
            rst         = (c == rst_at);
            if (c == pchg_at) prescale = PW'(16);
        end
        rx = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stop_err = 1'b0; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; par_en = 1'b0; prescale = PW'(8);
        strt_glitch = 1'b0; par_err = 1'b0; stop_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_edge_cnt", int'(edge_cnt), 0);
        chk("reset_busy", int'({busy, samp_en}), 0);
        chk("reset_pulses", int'({strt_en, deser_en, par_en_o, stop_en, valid, pfail, ferr}), 0);
`ifdef UART_RX_CTRL_ERR_CNT_EN
        chk("reset_err_cnt", int'(err_cnt), 0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        //            p   e  d      glen gl perr serr deser par stop val pf fe end  pulse
        vecs[0] = '{  8, 0, 8'h55,  0,  0, 0,   0,   8,   0,  1,   1,  0, 0,  80,  80};
        vecs[1] = '{ 16, 1, 8'hA3,  0,  0, 1,   0,   8,   1,  0,   0,  1, 0, 160, 160};
        vecs[2] = '{  8, 0, 8'h00,  3,  1, 0,   0,   0,   0,  0,   0,  0, 0,   8,  -1};
        vecs[3] = '{  8, 0, 8'hC6,  0,  0, 0,   1,   8,   0,  1,   0,  0, 1,  80,  80};
        vecs[4] = '{ 32, 1, 8'h0F,  0,  0, 0,   0,   8,   1,  1,   1,  0, 0, 352, 352};
        vecs[5] = '{ 16, 0, 8'hFF,  0,  0, 0,   0,   8,   0,  1,   1,  0, 0, 160, 160};

        for (int i = 0; i < 6; i++) begin
            run(vecs[i].p, vecs[i].e, 1, vecs[i].d, 8'h00, vecs[i].glen, vecs[i].gl,
                vecs[i].perr, vecs[i].serr, -1, -1, vecs[i].exp_end);
            chk($sformatf("v%0d_deser_cnt", i), r_deser, vecs[i].exp_deser);
            chk($sformatf("v%0d_deser_timing", i), r_deser_bad, 0);
            chk($sformatf("v%0d_strt_chk_cnt", i), r_strt, 1);
            chk($sformatf("v%0d_par_chk_cnt", i), r_par, vecs[i].exp_par);
            chk($sformatf("v%0d_stop_chk_cnt", i), r_stop, vecs[i].exp_stop);
            chk($sformatf("v%0d_valid_cnt", i), r_valid, vecs[i].exp_valid);
            chk($sformatf("v%0d_par_fail_cnt", i), r_pfail, vecs[i].exp_pfail);
            chk($sformatf("v%0d_frame_err_cnt", i), r_ferr, vecs[i].exp_ferr);
            chk($sformatf("v%0d_pulse_cycle", i), r_pulse_c, vecs[i].exp_pulse_c);
            chk($sformatf("v%0d_busy_profile", i), r_busy_bad, 0);
            chk($sformatf("v%0d_edge_cnt_profile", i), r_edge_bad, 0);
`ifdef UART_RX_CTRL_ERR_CNT_EN
            exp_err = exp_err + int'(vecs[i].gl | vecs[i].perr | vecs[i].serr);
            chk($sformatf("v%0d_err_cnt", i), int'(err_cnt), exp_err);
`endif
        end

        // Reset during data bit 3 (bit_cnt 4), then a clean frame.
        run(8, 0, 1, 8'h5A, 8'h00, 0, 0, 0, 0, 35, -1, 36);
        chk("rst_mid_outputs_zero", r_rst_bad, 0);
        chk("rst_mid_deser_cnt", r_deser, 3);
        chk("rst_mid_no_pulse", r_valid + r_pfail + r_ferr + r_stop, 0);
        chk("rst_mid_busy_profile", r_busy_bad, 0);
`ifdef UART_RX_CTRL_ERR_CNT_EN
        exp_err = 0;
        chk("rst_mid_err_cnt", int'(err_cnt), exp_err);
`endif
        run(8, 0, 1, 8'h55, 8'h00, 0, 0, 0, 0, -1, -1, 80);
        chk("post_rst_valid_cnt", r_valid, 1);
        chk("post_rst_valid_cycle", r_valid_c0, 80);

        // Two frames with no gap on the wire.
        run(8, 0, 2, 8'h55, 8'h3C, 0, 0, 0, 0, -1, -1, 160);
        chk("b2b_valid_cnt", r_valid, 2);
        chk("b2b_valid_first", r_valid_c0, 80);
        chk("b2b_valid_spacing", r_valid_c1 - r_valid_c0, 80);
        chk("b2b_deser_cnt", r_deser, 16);
        chk("b2b_deser_timing", r_deser_bad, 0);
        chk("b2b_busy_profile", r_busy_bad, 0);

        // Prescale changed to 16 mid-frame must not affect the frame in flight.
        run(8, 0, 1, 8'h96, 8'h00, 0, 0, 0, 0, -1, 20, 80);
        chk("pchg_valid_cycle", r_valid_c0, 80);
        chk("pchg_deser_cnt", r_deser, 8);
        chk("pchg_edge_cnt_profile", r_edge_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
